// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the double-dabble digit constants.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADD3_ADJ    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single BCD digit corrector for double-dabble: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] fixed
);

  assign fixed = (digit >= ADD3_THRESH) ? digit + ADD3_ADJ : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/done handshake; results are held until the next conversion.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_W-1:0]           bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      ovf
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [IN_W-1:0]  sh, sh_nxt;
  logic [ACC_W-1:0] acc, acc_adj, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sticky, sticky_nxt;
  logic             load_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (acc[g*DIGIT_W +: DIGIT_W]),
      .fixed (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // bcd/ovf only load on the edge that enters DONE, so they never show a partial value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      bcd    <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      sticky <= sticky_nxt;
      if (load_out) begin
        bcd <= acc_nxt;
        ovf <= sticky_nxt;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    sticky_nxt = sticky;
    load_out   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          sh_nxt     = bin;
          acc_nxt    = '0;
          sticky_nxt = 1'b0;
          cnt_nxt    = CNT_LOAD;
          state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        // Any 1 pushed out of the top digit means the value needs more digits than we have
        {acc_nxt, sh_nxt} = {acc_adj, sh} << 1;
        sticky_nxt        = sticky | acc_adj[ACC_W-1];
        cnt_nxt           = cnt - CNT_ONE;
        if (cnt == '0) begin
          state_nxt = DONE;
          load_out  = 1'b1;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a vector table for the default
// and a 10-bit instance, plus hand-written busy, reset-abort and back-to-back sequences.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start, start10;
  logic [6:0]  bin;
  logic [9:0]  bin10;
  logic        busy, busy10;
  logic        done, done10;
  logic [11:0] bcd, bcd10;
  logic        ovf, ovf10;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          wide;
    int unsigned value;
    logic [11:0] bcd;
    logic        ovf;
    bit          cmpBcd;
  } vec_t;

  vec_t vecs[11];

  bin2bcd_seq #(.IN_W(7), .DIGITS(3)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  bin2bcd_seq #(.IN_W(10), .DIGITS(3)) u_dut10 (
    .clk   (clk),
    .rst   (rst),
    .start (start10),
    .bin   (bin10),
    .busy  (busy10),
    .done  (done10),
    .bcd   (bcd10),
    .ovf   (ovf10)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] bcdOf(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts one conversion on the chosen instance and reports the edge at which done was seen
  task automatic applyStimulus(input bit wide, input int unsigned value, output int lat);
    lat = -1;
    if (wide) begin
      start10 = 1'b1;
      bin10   = 10'(value);
    end else begin
      start = 1'b1;
      bin   = 7'(value);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      start10 = 1'b0;
      if (lat < 0 && (wide ? done10 : done)) lat = i;
    end
  endtask

  initial begin
    int lat;
    int dones;
    int v;
    int edgeNo;
    int lastEdge;

    vecs[0]  = '{0, 0,    12'h000, 1'b0, 1};
    vecs[1]  = '{0, 127,  12'h127, 1'b0, 1};
    vecs[2]  = '{0, 98,   12'h098, 1'b0, 1};
    vecs[3]  = '{0, 10,   12'h010, 1'b0, 1};
    vecs[4]  = '{0, 9,    12'h009, 1'b0, 1};
    vecs[5]  = '{0, 55,   12'h055, 1'b0, 1};
    vecs[6]  = '{0, 100,  12'h100, 1'b0, 1};
    vecs[7]  = '{1, 999,  12'h999, 1'b0, 1};
    vecs[8]  = '{1, 512,  12'h512, 1'b0, 1};
    vecs[9]  = '{1, 1000, 12'h000, 1'b1, 0};
    vecs[10] = '{1, 1023, 12'h000, 1'b1, 0};

    rst = 1'b1; start = 1'b0; start10 = 1'b0; bin = '0; bin10 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bcd",   32'(bcd),    32'h000);
    checkOutput("rst_ovf",   32'(ovf),    32'd0);
    checkOutput("rst_done",  32'(done),   32'd0);
    checkOutput("rst_busy",  32'(busy),   32'd0);
    checkOutput("rst_bcd10", 32'(bcd10),  32'h000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: latency is counted from the edge that samples start (edge 1)
    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k].wide, vecs[k].value, lat);
      checkOutput($sformatf("latency_%0d", vecs[k].value), 32'(lat),
                  vecs[k].wide ? 32'd11 : 32'd8);
      if (vecs[k].cmpBcd)
        checkOutput($sformatf("bcd_%0d", vecs[k].value),
                    32'(vecs[k].wide ? bcd10 : bcd), 32'(vecs[k].bcd));
      checkOutput($sformatf("ovf_%0d", vecs[k].value),
                  32'(vecs[k].wide ? ovf10 : ovf), 32'(vecs[k].ovf));
    end

    // Start requests while busy must be ignored
    start = 1'b1; bin = 7'd45; dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 3 || i == 8) begin
        start = 1'b1;
        bin   = 7'd77;
      end
      if (i == 4) checkOutput("busy_mid", 32'(busy), 32'd1);
      if (done) dones++;
    end
    checkOutput("ignore_dones", 32'(dones), 32'd1);
    checkOutput("ignore_bcd",   32'(bcd),   32'h045);
    applyStimulus(1'b0, 77, lat);
    checkOutput("bcd_77_after", 32'(bcd), 32'h077);

    // Reset in the middle of a conversion
    start = 1'b1; bin = 7'd63;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_bcd",  32'(bcd),  32'h000);
    checkOutput("abort_ovf",  32'(ovf),  32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    dones = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("abort_no_done", 32'(dones), 32'd0);
    applyStimulus(1'b0, 21, lat);
    checkOutput("bcd_21_after_abort", 32'(bcd), 32'h021);

    // start held high: each done returns the value loaded just after the previous done
    start = 1'b1; bin = 7'd0; v = 0; edgeNo = 0; lastEdge = 0;
    while (v < 128 && edgeNo < 2000) begin
      @(posedge clk); #1;
      edgeNo++;
      if (done) begin
        checkOutput($sformatf("b2b_bcd_%0d", v), 32'(bcd), 32'(bcdOf(v)));
        if (v > 0) checkOutput("b2b_period", 32'(edgeNo - lastEdge), 32'd9);
        lastEdge = edgeNo;
        v++;
        bin = 7'(v);
      end
    end
    start = 1'b0;
    checkOutput("b2b_count", 32'(v), 32'd128);
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
